// File: rtl/vga_pkg.sv
// vga_pkg: shared mode and fade-state encodings plus default 640x480@60 timing.
package vga_pkg;
   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_PLAY = 2'd1,
      MODE_WIN  = 2'd2,
      MODE_LOSE = 2'd3
   } mode_t;
   typedef enum logic [1:0] {
      FADE_STEADY = 2'd0,
      FADE_OUT    = 2'd1,
      FADE_IN     = 2'd2
   } fade_state_t;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int CNT_W        = 10;
   localparam int ADDRH_W      = 10;
   localparam int ADDRV_W      = 9;
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters, raw active-low syncs, active flag and end-of-frame tick.
module vga_timing_gen import vga_pkg::*; #(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             pix_en,
   output logic [CNT_W-1:0] h,
   output logic [CNT_W-1:0] v,
   output logic             active,
   output logic             hs_raw,
   output logic             vs_raw,
   output logic             frame_tick
);
   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_ALAST = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   always_ff @(posedge clk) begin
      if (!resetn) begin
         h <= '0;
         v <= '0;
      end else if (pix_en) begin
         h <= (h == H_LAST) ? '0 : h + 1'b1;
         if (h == H_LAST) v <= (v == V_LAST) ? '0 : v + 1'b1;
      end
   end
   assign active     = (h < H_ACT) && (v < V_ACT);
   assign hs_raw     = !((h >= HS_BEG) && (h < HS_END));
   assign vs_raw     = !((v >= VS_BEG) && (v < VS_END));
   assign frame_tick = pix_en && (h == H_LAST) && (v == V_ALAST);
endmodule

// File: rtl/vga_display_ctrl.sv
// vga_display_ctrl: VGA timing, per-mode pixel colour and frame-boundary fade between modes.
module vga_display_ctrl import vga_pkg::*; #(
   parameter int                COLOUR_W    = 12,
   parameter int                H_ACTIVE    = DEF_H_ACTIVE,
   parameter int                H_FP        = DEF_H_FP,
   parameter int                H_SYNC      = DEF_H_SYNC,
   parameter int                H_BP        = DEF_H_BP,
   parameter int                V_ACTIVE    = DEF_V_ACTIVE,
   parameter int                V_FP        = DEF_V_FP,
   parameter int                V_SYNC      = DEF_V_SYNC,
   parameter int                V_BP        = DEF_V_BP,
   parameter int                FRAME_CNT_W = 16,
   parameter int                FADE_SHIFT  = 4,
   parameter logic [COLOUR_W-1:0] IDLE_COLOUR = 12'h0FF
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                pix_en,
   input  logic [1:0]          master_state,
   input  logic [COLOUR_W-1:0] game_colour,
   output logic [ADDRH_W-1:0]  addrh,
   output logic [ADDRV_W-1:0]  addrv,
   output logic                hs,
   output logic                vs,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                frame_tick,
   output logic                fade_busy
);
   localparam int CH = COLOUR_W / 3;
   localparam int PW = CH + FADE_SHIFT + 1;
   localparam logic [FADE_SHIFT:0]   LVL_FULL = {1'b1, {FADE_SHIFT{1'b0}}};
   localparam logic [CNT_W-1:0]      H_MID    = CNT_W'(H_ACTIVE / 2);
   localparam logic [CNT_W-1:0]      V_MID    = CNT_W'(V_ACTIVE / 2);
   localparam logic [COLOUR_W-1:0]   RED_FULL = {{CH{1'b1}}, {(COLOUR_W - CH){1'b0}}};
   logic [CNT_W-1:0]       h, v, dh, dv;
   logic                   active, hs_raw, vs_raw;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   mode_t                  ms, mode_q, mode_d;
   fade_state_t            st_q, st_d;
   logic [FADE_SHIFT:0]    lvl_q, lvl_d;
   logic [COLOUR_W-1:0]    win_colour, src_colour, faded;
   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk(clk),
      .resetn(resetn),
      .pix_en(pix_en),
      .h(h),
      .v(v),
      .active(active),
      .hs_raw(hs_raw),
      .vs_raw(vs_raw),
      .frame_tick(frame_tick)
   );
   assign addrh     = h;
   assign addrv     = v[ADDRV_W-1:0];
   assign ms        = mode_t'(master_state);
   assign fade_busy = st_q != FADE_STEADY;
   always_comb begin
      dh = (h >= H_MID) ? h - H_MID : H_MID - h;
      dv = (v >= V_MID) ? v - V_MID : V_MID - v;
      win_colour = COLOUR_W'(frame_cnt[FRAME_CNT_W-1 -: 8]) + COLOUR_W'(dh) + COLOUR_W'(dv);
      src_colour = (mode_q == MODE_IDLE) ? IDLE_COLOUR :
                   (mode_q == MODE_PLAY) ? game_colour :
                   (mode_q == MODE_WIN)  ? win_colour  :
                   (frame_cnt[5] ? RED_FULL : '0);
   end
   // level 2^FADE_SHIFT scales each channel by exactly one
   for (genvar c = 0; c < 3; c++) begin : g_ch
      assign faded[c*CH +: CH] = CH'((PW'(src_colour[c*CH +: CH]) * PW'(lvl_q)) >> FADE_SHIFT);
   end
   always_comb begin
      st_d   = st_q;
      lvl_d  = lvl_q;
      mode_d = mode_q;
      if (frame_tick) begin
         case (st_q)
            FADE_STEADY: st_d = (ms != mode_q) ? FADE_OUT : FADE_STEADY;
            FADE_OUT: begin
               if (ms == mode_q) st_d = FADE_IN;
               else begin
                  lvl_d = (lvl_q == '0) ? '0 : lvl_q - 1'b1;
                  if (lvl_d == '0) begin
                     mode_d = ms;
                     st_d   = FADE_IN;
                  end
               end
            end
            FADE_IN: begin
               if (ms != mode_q) st_d = FADE_OUT;
               else begin
                  lvl_d = (lvl_q == LVL_FULL) ? LVL_FULL : lvl_q + 1'b1;
                  st_d  = (lvl_d == LVL_FULL) ? FADE_STEADY : FADE_IN;
               end
            end
            default: st_d = FADE_STEADY;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         colour_out <= '0;
         hs         <= 1'b1;
         vs         <= 1'b1;
         frame_cnt  <= '0;
         mode_q     <= MODE_IDLE;
         st_q       <= FADE_STEADY;
         lvl_q      <= LVL_FULL;
      end else begin
         if (pix_en) begin
            colour_out <= active ? faded : '0;
            hs         <= hs_raw;
            vs         <= vs_raw;
         end
         if (frame_tick) frame_cnt <= frame_cnt + 1'b1;
         mode_q <= mode_d;
         st_q   <= st_d;
         lvl_q  <= lvl_d;
      end
   end
endmodule

// File: tb/tb_vga_display_ctrl.sv
// tb_vga_display_ctrl: randomized run of a shrunken raster against a frame-level reference model.
module tb_vga_display_ctrl;
   localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
   localparam int VA = 12, VFP = 1, VSY = 2, VBP = 2;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FP = HT * VT;
   localparam int FULL = 4;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        pix_en = 1'b1;
   logic [1:0]  master_state = 2'd0;
   logic [11:0] game_colour, colour_out;
   logic [9:0]  addrh;
   logic [8:0]  addrv;
   logic        hs, vs, frame_tick, fade_busy;
   int checks = 0, errors = 0;
   int m_n, m_fc, m_mode, m_lvl, m_ph, m_col, m_hs, m_vs;
   int m_ticks = 0;
   always #5 clk = ~clk;
   assign game_colour = {addrv[3:0], addrh[7:0]} ^ 12'h5A3;
   vga_display_ctrl #(
      .COLOUR_W(12), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .FRAME_CNT_W(8), .FADE_SHIFT(2), .IDLE_COLOUR(12'h0FF)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .pix_en(pix_en),
      .master_state(master_state),
      .game_colour(game_colour),
      .addrh(addrh),
      .addrv(addrv),
      .hs(hs),
      .vs(vs),
      .colour_out(colour_out),
      .frame_tick(frame_tick),
      .fade_busy(fade_busy)
   );
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (pix %0d frame %0d)", tag, got, exp, m_n, m_ticks);
      end
   endtask
   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction
   function automatic int src(input int h, input int v);
      case (m_mode)
         0:       return 'h0FF;
         1:       return (((v & 15) << 8) | (h & 255)) ^ 'h5A3;
         2:       return (m_fc + iabs(h - HA / 2) + iabs(v - VA / 2)) & 'hFFF;
         default: return ((m_fc & 32) != 0) ? 'hF00 : 0;
      endcase
   endfunction
   function automatic int fade(input int c, input int l);
      int r = 0;
      for (int k = 0; k < 3; k++) r |= ((((c >> (4 * k)) & 15) * l) >> 2) << (4 * k);
      return r;
   endfunction
   // Reference: one call per clock edge, driven by the inputs present at that edge.
   task automatic model();
      int h = m_n % HT;
      int v = m_n / HT;
      int ms = int'(master_state);
      if (!resetn) begin
         m_n = 0; m_fc = 0; m_mode = 0; m_lvl = FULL; m_ph = 0;
         m_col = 0; m_hs = 1; m_vs = 1;
      end else if (pix_en) begin
         m_col = (h < HA && v < VA) ? fade(src(h, v), m_lvl) : 0;
         m_hs = (h >= HA + HFP && h < HA + HFP + HSY) ? 0 : 1;
         m_vs = (v >= VA + VFP && v < VA + VFP + VSY) ? 0 : 1;
         if (h == HT - 1 && v == VA - 1) begin
            m_ticks++;
            m_fc = (m_fc + 1) % 256;
            if (m_ph == 0) begin
               if (ms != m_mode) m_ph = 1;
            end else if (m_ph == 1) begin
               if (ms == m_mode) m_ph = 2;
               else begin
                  if (m_lvl > 0) m_lvl--;
                  if (m_lvl == 0) begin m_mode = ms; m_ph = 2; end
               end
            end else begin
               if (ms != m_mode) m_ph = 1;
               else begin
                  if (m_lvl < FULL) m_lvl++;
                  if (m_lvl == FULL) m_ph = 0;
               end
            end
         end
         m_n = (m_n + 1) % FP;
      end
   endtask
   task automatic step();
      int h, v;
      @(posedge clk);
      model();
      @(negedge clk);
      h = m_n % HT;
      v = m_n / HT;
      chk("addrh", 32'(addrh), h);
      chk("addrv", 32'(addrv), v);
      chk("colour_out", 32'(colour_out), m_col);
      chk("hs", 32'(hs), m_hs);
      chk("vs", 32'(vs), m_vs);
      chk("frame_tick", 32'(frame_tick), (pix_en && h == HT - 1 && v == VA - 1) ? 1 : 0);
      chk("fade_busy", 32'(fade_busy), (m_ph != 0) ? 1 : 0);
   endtask
   // en_div > 0: pix_en every en_div clocks; en_div == 0: random 50% pix_en
   task automatic run(input int frames, input int en_div, input bit rnd_ms);
      int target = m_ticks + frames;
      int budget = (frames + 2) * FP * ((en_div == 0) ? 4 : en_div);
      int cyc = 0;
      while (m_ticks < target && cyc < budget) begin
         step();
         cyc++;
         pix_en = (en_div == 0) ? 1'($urandom_range(1)) : (cyc % en_div == 0);
         if (rnd_ms && $urandom_range(FP * 3) == 0) master_state = 2'($urandom_range(3));
      end
      chk("frame_budget", (m_ticks >= target) ? 1 : 0, 1);
   endtask
   initial begin
      repeat (3) step();
      resetn = 1'b1;
      run(2, 1, 1'b0);
      run(2, 4, 1'b0);
      master_state = 2'd1;
      run(10, 1, 1'b0);
      master_state = 2'd2;
      run(3, 1, 1'b0);
      master_state = 2'd1;
      run(8, 1, 1'b0);
      master_state = 2'd2;
      run(10, 0, 1'b0);
      master_state = 2'd3;
      run(40, 1, 1'b0);
      run(20, 0, 1'b1);
      pix_en = 1'b1;
      repeat ($urandom_range(300, 50)) step();
      resetn = 1'b0;
      pix_en = 1'b0;
      step();
      resetn = 1'b1;
      master_state = 2'd0;
      run(3, 1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
